// File: rtl/tt_lut_eval_pkg.sv
// Shared types and constants for the truth-table evaluator.
package tt_lut_pkg;

   // Control states: normal per-vector service, table enumeration, and
   // waiting for the final enumeration result to drain.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Truth table loaded at reset unless the instance overrides it.
   localparam logic [15:0] TT_DEFAULT = 16'h8F63;

   // Truth-table width for an n-input function.
   function automatic int tt_w(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_lut_eval_if.sv
// Streaming, configuration and sweep signals of the truth-table evaluator.
interface tt_lut_eval_if #(
   parameter int NUM_IN = 4
);
   import tt_lut_pkg::*;

   localparam int TT_W = tt_w(NUM_IN);

   // Configuration
   logic              cfg_we;
   logic [TT_W-1:0]   cfg_tt;
   logic              cfg_err;

   // Input vector stream
   logic              in_valid;
   logic              in_ready;
   logic [NUM_IN-1:0] in_vec;

   // Result stream
   logic              out_valid;
   logic              out_ready;
   logic              out_bit;
   logic [NUM_IN-1:0] out_idx;

   // Table enumeration
   logic              sweep_start;
   logic              sweep_busy;
   logic              sweep_done;

   // Driver side (testbench or upstream logic).
   modport master (
      output cfg_we, cfg_tt, in_valid, in_vec, out_ready, sweep_start,
      input  cfg_err, in_ready, out_valid, out_bit, out_idx, sweep_busy, sweep_done
   );

   // Evaluator side.
   modport slave (
      input  cfg_we, cfg_tt, in_valid, in_vec, out_ready, sweep_start,
      output cfg_err, in_ready, out_valid, out_bit, out_idx, sweep_busy, sweep_done
   );

endinterface

// File: rtl/tt_lut_eval_out_reg.sv
// Single-entry valid/ready output register. A new word may be loaded
// whenever the slot is empty or its current word leaves this cycle.
module tt_out_reg #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,    // only honoured while ld_o is high
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         ld_o,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign ld_o    = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // Refill or empty the slot when it is free; otherwise hold the word stable.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ld_o) begin
         valid_d = load_i;
         if (load_i) begin
            data_d = data_i;
         end
      end
   end

   // Slot state; the held word is cleared too so the outputs start at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/tt_lut_eval.sv
// Registered NUM_IN-input Boolean function evaluator driven by a run-time
// loadable truth table, with a sweep mode that streams every table entry.
module tt_lut_eval
   import tt_lut_pkg::*;
#(
   parameter int           NUM_IN  = 4,
   parameter int           TT_W    = tt_w(NUM_IN),
   parameter logic [255:0] TT_INIT = 256'(TT_DEFAULT)
) (
   input logic         clk,
   input logic         rst_n,
   tt_lut_eval_if.slave bus
);

   // Reset table, zero-extended or truncated to the table width.
   localparam logic [TT_W-1:0] TT_RST = TT_INIT[TT_W-1:0];

   state_e            state_q, state_d;
   logic [NUM_IN-1:0] cnt_q, cnt_d;
   logic [TT_W-1:0]   table_q, table_d;
   logic              cfg_err_q, cfg_err_d;
   logic              done_q, done_d;

   logic              ld;
   logic              load;
   logic [NUM_IN:0]   load_data;
   logic              in_rdy;
   logic              out_valid;
   logic [NUM_IN:0]   out_data;

   // Next state, table update and the word offered to the output register.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      table_d   = table_q;
      cfg_err_d = 1'b0;
      done_d    = 1'b0;
      in_rdy    = 1'b0;
      load      = 1'b0;
      load_data = {table_q[bus.in_vec], bus.in_vec};

      unique case (state_q)
         IDLE: begin
            // A sweep request wins over a pending vector in the same cycle.
            if (bus.sweep_start) begin
               state_d = SWEEP;
            end else begin
               in_rdy = ld;
               load   = bus.in_valid && ld;
            end
            // The lookup above reads table_q, so a vector accepted
            // alongside a write still sees the old table.
            if (bus.cfg_we) begin
               table_d = bus.cfg_tt;
            end
         end

         SWEEP: begin
            load_data = {table_q[cnt_q], cnt_q};
            cfg_err_d = bus.cfg_we;
            if (ld) begin
               load  = 1'b1;
               cnt_d = cnt_q + 1'b1;   // wraps to 0 after the last entry
               if (&cnt_q) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            cfg_err_d = bus.cfg_we;
            // Finish only once the last enumerated result has left.
            if (out_valid && bus.out_ready) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control, counter and table registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         table_q   <= TT_RST;
         cfg_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         table_q   <= table_d;
         cfg_err_q <= cfg_err_d;
         done_q    <= done_d;
      end
   end

   tt_out_reg #(
      .W(NUM_IN + 1)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .data_i  (load_data),
      .ready_i (bus.out_ready),
      .ld_o    (ld),
      .valid_o (out_valid),
      .data_o  (out_data)
   );

   assign bus.in_ready   = in_rdy;
   assign bus.out_valid  = out_valid;
   assign bus.out_bit    = out_data[NUM_IN];
   assign bus.out_idx    = out_data[NUM_IN-1:0];
   assign bus.cfg_err    = cfg_err_q;
   assign bus.sweep_busy = (state_q != IDLE);
   assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Testbench for tt_lut_eval: directed steps plus a randomized phase, all
// checked every cycle against a queue-based behavioural model.
module tb_tt_lut_eval;

   localparam int NUM_IN = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   tt_lut_eval_if #(.NUM_IN(NUM_IN)) bus ();

   tt_lut_eval #(.NUM_IN(NUM_IN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: table, contents of the one-entry output slot,
   // pending sweep results, and the expected status flags.
   logic [15:0] m_tt;
   int          reg_n;
   logic [4:0]  reg_v;
   logic [4:0]  sw_pend[$];
   bit          m_busy, m_done, m_cerr;
   logic [4:0]  dut_log[$];   // {out_bit, out_idx} of every transfer seen

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tt   = 16'h8F63;
      reg_n  = 0;
      reg_v  = '0;
      sw_pend.delete();
      m_busy = 0;
      m_done = 0;
      m_cerr = 0;
   endtask

   // Compare the DUT against the model, then advance the model across the
   // coming rising edge using the inputs currently driven.
   task automatic step();
      bit         ld, xfer, nd, ncerr, exp_rdy;
      @(negedge clk);
      exp_rdy = !m_busy && (reg_n == 0 || bus.out_ready) && !bus.sweep_start;
      chk("out_valid", 32'(bus.out_valid), 32'(reg_n));
      if (reg_n == 1) begin
         chk("out_bit", 32'(bus.out_bit), 32'(reg_v[4]));
         chk("out_idx", 32'(bus.out_idx), 32'(reg_v[3:0]));
      end
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("sweep_busy", 32'(bus.sweep_busy), 32'(m_busy));
      chk("sweep_done", 32'(bus.sweep_done), 32'(m_done));
      chk("cfg_err", 32'(bus.cfg_err), 32'(m_cerr));
      if (bus.out_valid && bus.out_ready) dut_log.push_back({bus.out_bit, bus.out_idx});

      ld    = (reg_n == 0) || bus.out_ready;
      xfer  = (reg_n == 1) && bus.out_ready;
      nd    = m_busy && (sw_pend.size() == 0) && xfer;
      ncerr = bus.cfg_we && m_busy;
      if (xfer) reg_n = 0;
      if (ld) begin
         if (m_busy) begin
            if (sw_pend.size() > 0) begin
               reg_v = sw_pend.pop_front();
               reg_n = 1;
            end
         end else if (!bus.sweep_start && bus.in_valid) begin
            reg_v = {m_tt[bus.in_vec], bus.in_vec};
            reg_n = 1;
         end
      end
      if (!m_busy) begin
         if (bus.cfg_we) m_tt = bus.cfg_tt;
         if (bus.sweep_start) begin
            m_busy = 1;
            for (int i = 0; i < 16; i++) sw_pend.push_back({m_tt[i], 4'(i)});
         end
      end else if (nd) begin
         m_busy = 0;
      end
      m_done = nd;
      m_cerr = ncerr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_we      = 1'b0;
      bus.cfg_tt      = '0;
      bus.in_valid    = 1'b0;
      bus.in_vec      = '0;
      bus.sweep_start = 1'b0;
   endtask

   // Turn the logged sweep stream into a table value and check ordering.
   task automatic check_sweep_log(input string tag, input logic [15:0] exp_tt);
      logic [15:0] bits;
      bits = '0;
      chk({tag, "_count"}, 32'(dut_log.size()), 32'd16);
      foreach (dut_log[i]) begin
         if (i < 16) begin
            chk({tag, "_idx"}, 32'(dut_log[i][3:0]), 32'(i));
            bits[i] = dut_log[i][4];
         end
      end
      chk({tag, "_bits"}, 32'(bits), 32'(exp_tt));
   endtask

   initial begin
      int vecs[5];
      int bits_exp[5];
      vecs     = '{0, 2, 5, 12, 15};
      bits_exp = '{1, 0, 1, 0, 1};

      // Reset state
      rst_n = 1'b0;
      idle_inputs();
      bus.out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_bit", 32'(bus.out_bit), 0);
      chk("rst_out_idx", 32'(bus.out_idx), 0);
      chk("rst_busy", 32'(bus.sweep_busy), 0);
      chk("rst_done", 32'(bus.sweep_done), 0);
      chk("rst_cfg_err", 32'(bus.cfg_err), 0);
      rst_n = 1'b1;
      step();

      // Back-to-back lookups, one-cycle latency, no bubbles
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_vec   = 4'(vecs[i]);
         step();
         chk("t1_valid", 32'(bus.out_valid), 1);
         chk("t1_bit", 32'(bus.out_bit), 32'(bits_exp[i]));
         chk("t1_idx", 32'(bus.out_idx), 32'(vecs[i]));
      end
      bus.in_valid = 1'b0;
      step();

      // Backpressure holds the result stable
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'd8;
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_valid", 32'(bus.out_valid), 1);
         chk("t2_bit", 32'(bus.out_bit), 1);
         chk("t2_idx", 32'(bus.out_idx), 8);
         chk("t2_in_ready", 32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      step();
      chk("t2_in_ready_after", 32'(bus.in_ready), 1);
      step();

      // Table write in the same cycle as an accept uses the old table
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'd0;
      bus.cfg_we   = 1'b1;
      bus.cfg_tt   = 16'h0000;
      step();
      chk("t3_old_table", 32'(bus.out_bit), 1);
      bus.cfg_we = 1'b0;
      step();
      chk("t3_new_table", 32'(bus.out_bit), 0);
      idle_inputs();
      bus.cfg_we = 1'b1;
      bus.cfg_tt = 16'h8F63;
      step();
      bus.cfg_we = 1'b0;
      step();

      // Sweep with out_ready toggling every cycle
      dut_log.delete();
      bus.sweep_start = 1'b1;
      step();
      bus.sweep_start = 1'b0;
      for (int c = 0; c < 200 && m_busy; c++) begin
         bus.out_ready = ~bus.out_ready;
         step();
      end
      chk("t4_finished", 32'(m_busy), 0);
      bus.out_ready = 1'b1;
      step();
      check_sweep_log("t4", 16'h8F63);

      // Rejected table write in the middle of a sweep
      dut_log.delete();
      bus.sweep_start = 1'b1;
      step();
      bus.sweep_start = 1'b0;
      for (int c = 0; c < 5; c++) step();
      bus.cfg_we = 1'b1;
      bus.cfg_tt = 16'hFFFF;
      step();
      bus.cfg_we = 1'b0;
      chk("t5_cfg_err", 32'(bus.cfg_err), 1);
      for (int c = 0; c < 200 && m_busy; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      bus.out_ready = 1'b1;
      step();
      check_sweep_log("t5", 16'h8F63);
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'd12;
      step();
      chk("t5_after_bit", 32'(bus.out_bit), 0);
      bus.in_valid = 1'b0;
      step();

      // Asynchronous reset during a stalled sweep
      bus.sweep_start = 1'b1;
      step();
      bus.sweep_start = 1'b0;
      step();
      step();
      bus.out_ready = 1'b0;
      step();
      step();
      chk("t6_pre_valid", 32'(bus.out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(bus.out_valid), 0);
      chk("t6_rst_busy", 32'(bus.sweep_busy), 0);
      chk("t6_rst_done", 32'(bus.sweep_done), 0);
      chk("t6_rst_bit", 32'(bus.out_bit), 0);
      model_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 4'd3;
      step();
      chk("t6_after_valid", 32'(bus.out_valid), 1);
      chk("t6_after_bit", 32'(bus.out_bit), 0);
      bus.in_valid = 1'b0;
      step();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         bus.in_valid    = 1'($urandom_range(0, 1));
         bus.in_vec      = 4'($urandom_range(0, 15));
         bus.out_ready   = ($urandom_range(0, 3) != 0);
         bus.cfg_we      = ($urandom_range(0, 15) == 0);
         bus.cfg_tt      = 16'($urandom);
         bus.sweep_start = ($urandom_range(0, 40) == 0);
         step();
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 100 && (m_busy || reg_n != 0); c++) step();
      chk("rand_drained", 32'(m_busy), 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound in case a wait above never completes.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
